// File: rtl/simple_alu.sv
// simple_alu: registered signed ALU with zero/negative/carry/overflow flags
module simple_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] bus_a,
  input  logic [WIDTH-1:0] bus_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH-1:0] res_d, res_q;
  logic             zero_d, zero_q, neg_d, neg_q, carry_d, carry_q, ovf_d, ovf_q;
  logic [WIDTH:0]   sum, diff;
  logic             a_msb, b_msb;
  assign sum   = {1'b0, bus_a} + {1'b0, bus_b};
  assign diff  = {1'b0, bus_a} - {1'b0, bus_b};
  assign a_msb = bus_a[WIDTH-1];
  assign b_msb = bus_b[WIDTH-1];
  // Compute the next result and flags for the selected operation
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (alu_sel)
      3'b000: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      end
      3'b001: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
        ovf_d   = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
      end
      3'b010: res_d = bus_a & bus_b;
      3'b011: res_d = bus_a | bus_b;
      3'b100: res_d = bus_a ^ bus_b;
      3'b101: res_d = ~bus_a;
      3'b110: begin
        res_d   = {bus_a[WIDTH-2:0], 1'b0};
        carry_d = a_msb;
        ovf_d   = a_msb ^ bus_a[WIDTH-2];
      end
      default: begin
        res_d   = {a_msb, bus_a[WIDTH-1:1]};
        carry_d = bus_a[0];
      end
    endcase
    zero_d = res_d == '0;
    neg_d  = res_d[WIDTH-1];
  end
  // Register result and flags; reset overrides any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end
  assign alu_out  = res_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_simple_alu.sv
// tb_simple_alu: directed vector bench for simple_alu
module tb_simple_alu;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_sel;
  logic [7:0] bus_a, bus_b, alu_out;
  logic       zero, negative, carry, overflow;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } vec_t;

  simple_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .alu_sel(alu_sel), .bus_a(bus_a), .bus_b(bus_b),
    .alu_out(alu_out), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] r, input logic z, input logic n,
                           input logic c, input logic v);
    check({name, ".out"}, alu_out, r);
    check({name, ".zero"}, {7'd0, zero}, {7'd0, z});
    check({name, ".neg"}, {7'd0, negative}, {7'd0, n});
    check({name, ".carry"}, {7'd0, carry}, {7'd0, c});
    check({name, ".ovf"}, {7'd0, overflow}, {7'd0, v});
  endtask

  task automatic step(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    alu_sel = s;
    bus_a   = a;
    bus_b   = b;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{3'b000, 8'd5,   8'd10,  8'd15,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 8'd127, 8'd1,   8'h80,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'b000, 8'hFF,  8'd1,   8'h00,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b000, 8'h80,  8'h80,  8'h00,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{3'b001, 8'd30,  8'd10,  8'd20,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b001, 8'd5,   8'd10,  8'hFB,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{3'b001, 8'h80,  8'd1,   8'h7F,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{3'b001, 8'd0,   8'd0,   8'h00,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b010, 8'd5,   8'd10,  8'h00,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b011, 8'd5,   8'd10,  8'h0F,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b100, 8'd5,   8'd10,  8'h0F,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b101, 8'd5,   8'd10,  8'hFA,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3'b110, 8'hC1,  8'd0,   8'h82,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{3'b110, 8'h41,  8'd0,   8'h82,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{3'b110, 8'h80,  8'hFF,  8'h00,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{3'b111, 8'h81,  8'd0,   8'hC0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{3'b111, 8'h01,  8'hFF,  8'h00,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{3'b100, 8'hFF,  8'hFF,  8'h00,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{3'b010, 8'hF0,  8'hAA,  8'hA0,  1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    step(3'b000, 8'd127, 8'd1);
    check_all("reset1", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3'b110, 8'h41, 8'h55);
    check_all("reset2", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].sel, vecs[i].a, vecs[i].b);
      check_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v);
    end

    step(3'b000, 8'd127, 8'd1);
    check_all("pre_rst", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    step(3'b110, 8'hC1, 8'd0);
    check_all("mid_rst", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(3'b001, 8'd5, 8'd10);
    check_all("post_rst", 8'hFB, 1'b0, 1'b1, 1'b1, 1'b0);
    #3;
    check_all("hold", 8'hFB, 1'b0, 1'b1, 1'b1, 1'b0);
    step(3'b111, 8'h81, 8'd0);
    check_all("post_rst2", 8'hC0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
